rocket_frame_readout: RTL and testbench

//  Parametrised successor to the fixed 53-word counts readout path for the rocket TM link.
//  On collect_done it snapshots NWORDS science words and pulses cnt_clr/cnt_start so the

---
 rtl/rocket_frame_readout_if.sv | 26 ++
 rtl/rocket_frame_readout.sv | 93 +++++++++
 tb/tb_rocket_frame_readout.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/rocket_frame_readout_if.sv
// rocket_frame_readout_if: collection handshake, snapshot words and rocket serial link.
interface rocket_frame_readout_if #(
    parameter int WORD_W = 10,
    parameter int NWORDS = 53
);
    logic                       collect_done;
    logic [NWORDS*WORD_W-1:0]   words_in;
    logic                       gtclk;
    logic                       invload;
    logic                       data_out;
    logic                       cnt_clr;
    logic                       cnt_start;
    logic                       busy;
    logic                       frame_done;
    logic                       overrun;

    modport master (
        output collect_done, words_in, gtclk, invload,
        input  data_out, cnt_clr, cnt_start, busy, frame_done, overrun
    );

    modport slave (
        input  collect_done, words_in, gtclk, invload,
        output data_out, cnt_clr, cnt_start, busy, frame_done, overrun
    );
endinterface

// File: rtl/rocket_frame_readout.sv
// rocket_frame_readout: snapshots science words and serves them to the rocket TM link as
// SYNC, NWORDS data words, checksum; each word loaded on invload, shifted MSB-first on gtclk.
module rocket_frame_readout #(
    parameter int                WORD_W    = 10,
    parameter int                NWORDS    = 53,
    parameter logic [WORD_W-1:0] SYNC_WORD = WORD_W'('h2E5),
    parameter logic [WORD_W-1:0] FILL_WORD = '0,
    parameter int                IDX_W     = 6
) (
    input logic                     clk50,
    input logic                     rst_n,
    rocket_frame_readout_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SNAP, SEND} state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NWORDS + 1);

    state_t                     r_state, w_state_nx;
    logic [2:0]                 r_gt_sync, r_ld_sync;
    logic [NWORDS*WORD_W-1:0]   r_buf;
    logic [WORD_W-1:0]          r_sr, r_sum, w_word, w_load_val;
    logic [IDX_W-1:0]           r_idx, w_sel;
    logic                       r_data_out, r_cnt_clr, r_cnt_start, r_busy, r_frame_done, r_overrun;
    logic                       w_gt_rise, w_ld_fall, w_accept, w_is_data, w_last_ld, w_send_ld;

    // [1] is the synchronised level, [2] its previous value for edge detection
    assign w_gt_rise = r_gt_sync[1] & ~r_gt_sync[2];
    assign w_ld_fall = ~r_ld_sync[1] & r_ld_sync[2];
    assign w_accept  = (r_state == IDLE) && bus.collect_done;
    assign w_sel     = r_idx - 1'b1;
    assign w_word    = r_buf[w_sel*WORD_W +: WORD_W];
    assign w_is_data = (r_idx != '0) && (r_idx != LAST);
    assign w_send_ld = (r_state == SEND) && w_ld_fall;

    always_comb begin
        w_state_nx = r_state;
        w_load_val = FILL_WORD;
        w_last_ld  = 1'b0;
        case (r_state)
            IDLE: w_state_nx = bus.collect_done ? SNAP : IDLE;
            SNAP: w_state_nx = SEND;
            SEND: begin
                w_load_val = (r_idx == '0) ? SYNC_WORD : (r_idx == LAST) ? r_sum : w_word;
                w_last_ld  = w_ld_fall && (r_idx == LAST);
                w_state_nx = w_last_ld ? IDLE : SEND;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            r_gt_sync    <= '0;
            r_ld_sync    <= '1;
            r_sr         <= FILL_WORD;
            r_data_out   <= 1'b0;
            r_buf        <= '0;
            r_sum        <= '0;
            r_idx        <= '0;
            r_cnt_clr    <= 1'b0;
            r_cnt_start  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_gt_sync    <= {r_gt_sync[1:0], bus.gtclk};
            r_ld_sync    <= {r_ld_sync[1:0], bus.invload};
            r_data_out   <= r_sr[WORD_W-1];
            // a load in the same cycle as a shift edge wins; the shift is dropped
            r_sr         <= w_ld_fall ? w_load_val : w_gt_rise ? {r_sr[WORD_W-2:0], 1'b0} : r_sr;
            r_buf        <= w_accept ? bus.words_in : r_buf;
            r_sum        <= w_accept ? '0 : (w_send_ld && w_is_data) ? r_sum + w_word : r_sum;
            r_idx        <= (r_state == SNAP) ? '0 : w_send_ld ? r_idx + 1'b1 : r_idx;
            r_cnt_clr    <= w_accept;
            r_cnt_start  <= r_state == SNAP;
            r_busy       <= (r_state == SNAP) ? 1'b1 : w_last_ld ? 1'b0 : r_busy;
            r_frame_done <= w_last_ld;
            r_overrun    <= r_overrun | (bus.collect_done && r_state != IDLE);
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.cnt_clr    = r_cnt_clr;
    assign bus.cnt_start  = r_cnt_start;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;
    assign bus.overrun    = r_overrun;
endmodule

// File: tb/tb_rocket_frame_readout.sv
// tb_rocket_frame_readout: drives the rocket load/gate protocol and checks every served word
// against a scoreboard of expected frames, plus reset, overrun and edge-collision cases.
module tb_rocket_frame_readout;
    localparam int W = 10;
    localparam int N = 53;
    localparam logic [W-1:0] SYNC = 10'h2E5;
    localparam logic [W-1:0] FILL = 10'h000;

    typedef struct {
        logic [W-1:0] w_even;
        logic [W-1:0] w_odd;
        bit           inc;
        logic [W-1:0] cks;
    } vec_t;

    logic clk50 = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   n_clr = 0;
    int   n_done = 0;
    logic [W-1:0] sb[$];
    vec_t vecs[4];

    rocket_frame_readout_if #(.WORD_W(W), .NWORDS(N)) bus();

    rocket_frame_readout #(.WORD_W(W), .NWORDS(N), .SYNC_WORD(SYNC), .FILL_WORD(FILL), .IDX_W(6)) dut (
        .clk50 (clk50),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #10 clk50 = ~clk50;

    always @(posedge clk50) begin
        if (bus.cnt_clr)    n_clr++;
        if (bus.frame_done) n_done++;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [W-1:0] wgen(input vec_t v, input int k);
        return ((k % 2 == 0) ? v.w_even : v.w_odd) + (v.inc ? W'(k + 1) : W'(0));
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk50);
    endtask

    // one rocket word: invload low for ld_cyc cycles (optionally with a gtclk rise), then 10 bits
    task automatic read_word(input int ld_cyc, input bit simul);
        logic [W-1:0] got, exp;
        got = '0;
        bus.invload = 1'b0;
        if (simul) bus.gtclk = 1'b1;
        cycles(ld_cyc);
        bus.invload = 1'b1;
        cycles(6);
        bus.gtclk = 1'b0;
        cycles(2);
        for (int b = W - 1; b >= 0; b--) begin
            got[b] = bus.data_out;
            bus.gtclk = 1'b1;
            cycles(3);
            bus.gtclk = 1'b0;
            cycles(3);
        end
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL word scoreboard_empty got=%0h", got);
        end else begin
            exp = sb.pop_front();
            chk("word", got, exp);
        end
    endtask

    task automatic read_n(input int n);
        repeat (n) read_word(3, 1'b0);
    endtask

    task automatic set_words(input vec_t v);
        for (int k = 0; k < N; k++) bus.words_in[k*W +: W] = wgen(v, k);
    endtask

    task automatic start_frame(input vec_t v);
        set_words(v);
        bus.collect_done = 1'b1;
        cycles(1);
        bus.collect_done = 1'b0;
        chk("cnt_clr_pulse", bus.cnt_clr, 1'b1);
        chk("cnt_start_early", bus.cnt_start, 1'b0);
        cycles(1);
        chk("cnt_clr_end", bus.cnt_clr, 1'b0);
        chk("cnt_start_pulse", bus.cnt_start, 1'b1);
        chk("busy_set", bus.busy, 1'b1);
        sb.push_back(SYNC);
        for (int k = 0; k < N; k++) sb.push_back(wgen(v, k));
        sb.push_back(v.cks);
    endtask

    task automatic finish_frame(input int remaining);
        int d0;
        d0 = n_done;
        read_n(remaining - 1);
        chk("frame_done_early", n_done, d0);
        read_n(1);
        chk("frame_done_count", n_done, d0 + 1);
        chk("busy_clear", bus.busy, 1'b0);
    endtask

    task automatic check_idle_outputs(input string nm);
        chk({nm, "_data_out"}, bus.data_out, 1'b0);
        chk({nm, "_busy"}, bus.busy, 1'b0);
        chk({nm, "_frame_done"}, bus.frame_done, 1'b0);
        chk({nm, "_overrun"}, bus.overrun, 1'b0);
        chk({nm, "_cnt_clr"}, bus.cnt_clr, 1'b0);
        chk({nm, "_cnt_start"}, bus.cnt_start, 1'b0);
    endtask

    initial begin
        int c0;
        vecs[0] = '{w_even: 10'h000, w_odd: 10'h000, inc: 1'b1, cks: 10'h197};
        vecs[1] = '{w_even: 10'h3FF, w_odd: 10'h3FF, inc: 1'b0, cks: 10'h3CB};
        vecs[2] = '{w_even: 10'h2AA, w_odd: 10'h155, inc: 1'b0, cks: 10'h290};
        vecs[3] = '{w_even: 10'h200, w_odd: 10'h001, inc: 1'b0, cks: 10'h21A};
        bus.collect_done = 1'b0;
        bus.words_in     = '0;
        bus.gtclk        = 1'b0;
        bus.invload      = 1'b1;
        cycles(3);
        rst_n = 1'b1;
        cycles(2);
        check_idle_outputs("reset");

        // T1: loads with nothing pending serve fill words
        repeat (3) sb.push_back(FILL);
        read_n(3);
        chk("t1_busy", bus.busy, 1'b0);
        chk("t1_frame_done", n_done, 0);

        // T2/T3 and extra patterns: full frames from the vector table
        for (int i = 0; i < 4; i++) begin
            start_frame(vecs[i]);
            finish_frame(N + 2);
        end

        // T4: collect_done during data word 20 is rejected
        start_frame(vecs[0]);
        read_n(21);
        c0 = n_clr;
        set_words(vecs[1]);
        bus.collect_done = 1'b1;
        cycles(1);
        bus.collect_done = 1'b0;
        cycles(3);
        chk("t4_overrun", bus.overrun, 1'b1);
        chk("t4_no_cnt_clr", n_clr, c0);
        chk("t4_busy", bus.busy, 1'b1);
        finish_frame(N + 2 - 21);
        chk("t4_overrun_sticky", bus.overrun, 1'b1);

        // T5: 1-cycle load pulse, then load colliding with a gate edge
        start_frame(vecs[2]);
        read_word(1, 1'b0);
        read_word(2, 1'b1);
        read_word(1, 1'b1);
        finish_frame(N + 2 - 3);

        // T6: reset during data word 30
        start_frame(vecs[3]);
        read_n(30);
        rst_n = 1'b0;
        cycles(1);
        check_idle_outputs("t6_reset");
        rst_n = 1'b1;
        sb.delete();
        cycles(2);
        sb.push_back(FILL);
        read_n(1);
        start_frame(vecs[3]);
        finish_frame(N + 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
